// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and I/O handshake state for segmented_memory_io.
// Register offsets are relative to IO_BASE, which sits directly above the data segments.
package mem_map_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      BUSY
   } io_state_t;

   localparam int STATUS_OFS    = 0;
   localparam int CONTROL_OFS   = 1;
   localparam int FAULTADDR_OFS = 2;
   localparam int IO_REGS       = 3;

   localparam int ST_PENDING = 0;
   localparam int ST_BUSY    = 1;
   localparam int ST_OVERRUN = 2;

   localparam int CT_ACK       = 0;
   localparam int CT_DONE      = 1;
   localparam int CT_CLR_OVR   = 2;
   localparam int CT_CLR_FAULT = 3;

endpackage

// File: rtl/segmented_memory_io_if.sv
// Data-port bundle between the CPU core (master) and segmented_memory_io (slave).
// rd2/rd2_valid return one cycle after a read request.
interface segmented_memory_io_if #(
   parameter int WIDTH = 32
);
   logic             req;
   logic             we;
   logic [WIDTH-1:0] a2;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rd2;
   logic             rd2_valid;

   modport master (
      output req, we, a2, wd,
      input  rd2, rd2_valid
   );

   modport slave (
      input  req, we, a2, wd,
      output rd2, rd2_valid
   );
endinterface

// File: rtl/segmented_memory_io_data_bank.sv
// data_bank: single-port synchronous RAM, one per data segment.
// rd only changes on a read, so it holds its value across writes and idle cycles.
module data_bank #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 102,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wd;
         else    rd        <= mem[addr];
      end
   end

endmodule

// File: rtl/segmented_memory_io.sv
// Segmented instruction/data memory with start/busy/done I/O registers above the data banks.
// Optional MEM_FAULT_EN adds the sticky out-of-range fault flag and FAULT_ADDR capture.
module segmented_memory_io
   import mem_map_pkg::*;
#(
   parameter int INSTRUCTIONWIDTH = 24,
   parameter int WIDTH            = 32,
   parameter int IMEM_DEPTH       = 256,
   parameter int NSEG             = 2,
   parameter int SEG_DEPTH        = 102,
   parameter logic [IMEM_DEPTH*INSTRUCTIONWIDTH-1:0] IMEM_INIT = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            a1,
   output logic [INSTRUCTIONWIDTH-1:0] rd1,
   segmented_memory_io_if.slave        bus,
   input  logic                        start_io,
   output logic                        io_busy,
   output logic                        io_done,
   output logic                        fault
);

   localparam int IO_BASE = NSEG * SEG_DEPTH;
   localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int OW  = (SEG_DEPTH > 1) ? $clog2(SEG_DEPTH) : 1;
   localparam int SW  = (NSEG > 1) ? $clog2(NSEG) : 1;

   logic [INSTRUCTIONWIDTH-1:0] imem [IMEM_DEPTH];

   for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
      assign imem[i] = IMEM_INIT[i*INSTRUCTIONWIDTH +: INSTRUCTIONWIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd1 <= '0;
      else if (a1 < WIDTH'(IMEM_DEPTH))
         rd1 <= imem[a1[IAW-1:0]];
      else
         rd1 <= '0;
   end

   logic          in_mem;
   logic [SW-1:0] seg_idx;
   logic [OW-1:0] seg_ofs;

   // Descending compare chain: the lowest matching segment bound wins.
   always_comb begin
      in_mem  = 1'b0;
      seg_idx = '0;
      seg_ofs = '0;
      for (int k = NSEG - 1; k >= 0; k--) begin
         if (bus.a2 < WIDTH'((k + 1) * SEG_DEPTH)) begin
            in_mem  = 1'b1;
            seg_idx = SW'(k);
            seg_ofs = OW'(bus.a2 - WIDTH'(k * SEG_DEPTH));
         end
      end
   end

   logic is_status;
   logic is_ctrl;
   logic rd_req;
   logic ctrl_wr;

   assign is_status = bus.a2 == WIDTH'(IO_BASE + STATUS_OFS);
   assign is_ctrl   = bus.a2 == WIDTH'(IO_BASE + CONTROL_OFS);
   assign rd_req    = bus.req & ~bus.we;
   assign ctrl_wr   = bus.req & bus.we & is_ctrl;

   logic [WIDTH-1:0] bank_rd [NSEG];

   for (genvar k = 0; k < NSEG; k++) begin : g_bank
      data_bank #(
         .WIDTH (WIDTH),
         .DEPTH (SEG_DEPTH)
      ) u_bank (
         .clk  (clk),
         .en   (!rst && bus.req && in_mem && seg_idx == SW'(k)),
         .we   (bus.we),
         .addr (seg_ofs),
         .wd   (bus.wd),
         .rd   (bank_rd[k])
      );
   end

   io_state_t state;
   logic      overrun;

`ifdef MEM_FAULT_EN
   logic [WIDTH-1:0] fault_addr;
   logic             fault_set;
   logic             is_faddr;

   assign is_faddr  = bus.a2 == WIDTH'(IO_BASE + FAULTADDR_OFS);
   assign fault_set = bus.req && bus.a2 >= WIDTH'(IO_BASE + IO_REGS);

   // Only the first fault is captured; a new fault beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (fault_set) begin
         fault <= 1'b1;
         if (!fault) fault_addr <= bus.a2;
      end else if (ctrl_wr && bus.wd[CT_CLR_FAULT]) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end
   end
`else
   assign fault = 1'b0;
`endif

   logic [WIDTH-1:0] io_rdata;

   always_comb begin
      io_rdata = '0;
      if (is_status) begin
         io_rdata[ST_PENDING] = state == PENDING;
         io_rdata[ST_BUSY]    = state == BUSY;
         io_rdata[ST_OVERRUN] = overrun;
      end
`ifdef MEM_FAULT_EN
      if (is_faddr) io_rdata = fault_addr;
`endif
   end

   logic             from_mem;
   logic [SW-1:0]    seg_q;
   logic [WIDTH-1:0] io_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rd2_valid <= 1'b0;
         from_mem      <= 1'b0;
         seg_q         <= '0;
         io_q          <= '0;
      end else begin
         bus.rd2_valid <= rd_req;
         if (rd_req) begin
            from_mem <= in_mem;
            seg_q    <= seg_idx;
            io_q     <= io_rdata;
         end
      end
   end

   assign bus.rd2 = from_mem ? bank_rd[seg_q] : io_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         io_busy <= 1'b0;
         io_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         io_done <= 1'b0;
         if (start_io && state != IDLE)
            overrun <= 1'b1;
         else if (ctrl_wr && bus.wd[CT_CLR_OVR])
            overrun <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_io) state <= PENDING;
            end
            PENDING: begin
               if (ctrl_wr && bus.wd[CT_ACK]) begin
                  state   <= BUSY;
                  io_busy <= 1'b1;
               end
            end
            BUSY: begin
               if (ctrl_wr && bus.wd[CT_DONE]) begin
                  state   <= IDLE;
                  io_busy <= 1'b0;
                  io_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
